// File: rtl/uart_recv.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_recv
// Purpose  : 8N1 serial receiver with single mid-bit sampling, framing-error
//            pulse and a break state that waits for the line to go idle.
// Revision : 1.0 - initial release
// ============================================================================
module uart_recv #(
    parameter int CLKS_PER_BIT = 26,
    parameter int CNT_W        = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RXD,
    output logic [7:0] DATA,
    output logic       DATA_READY,
    output logic       FRAME_ERR,
    output logic       IDLE
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] c_HALF_BIT   = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] c_BIT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE    = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             ready_q, ready_d;
    logic             ferr_q, ferr_d;
    logic             sync1_q, sync1_d;
    logic             rx_s_q, rx_s_d;
    logic             rx_prev_q, rx_prev_d;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            ready_q   <= 1'b0;
            ferr_q    <= 1'b0;
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
            ferr_q    <= ferr_d;
            sync1_q   <= sync1_d;
            rx_s_q    <= rx_s_d;
            rx_prev_q <= rx_prev_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        data_d    = data_q;
        ready_d   = 1'b0;
        ferr_d    = 1'b0;
        sync1_d   = RXD;
        rx_s_d    = sync1_q;
        rx_prev_d = rx_s_q;

        case (state_q)
            ST_IDLE: begin
                if (!rx_s_q && rx_prev_q) begin
                    state_d = ST_START;
                    cnt_d   = c_HALF_BIT;
                end
            end
            // The half-bit load happens on the entry edge itself, so the start
            // sample fires one count earlier than the full-bit samples.
            ST_START: begin
                if (cnt_q == c_CNT_ONE) begin
                    if (rx_s_q) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_DATA;
                        cnt_d   = c_BIT_RELOAD;
                        bit_d   = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q - c_CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    cnt_d   = c_BIT_RELOAD;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_q - c_CNT_ONE;
                end
            end
            ST_STOP: begin
                if (cnt_q == '0) begin
                    if (rx_s_q) begin
                        data_d  = shift_q;
                        ready_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q - c_CNT_ONE;
                end
            end
            ST_BREAK: begin
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign DATA       = data_q;
    assign DATA_READY = ready_q;
    assign FRAME_ERR  = ferr_q;
    assign IDLE       = (state_q == ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_recv.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_recv
// Purpose  : Randomised and directed checks of uart_recv against a line-trace
//            receiver model, at 26 and 4 clocks per bit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_recv;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd26, rxd4;
    logic [7:0] data26, data4;
    logic       rdy26, rdy4, fe26, fe4, idle26, idle4;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] mdata26, mdata4;

    // One entry per cycle: line value driven, and {IDLE, DATA_READY, FRAME_ERR, DATA}
    bit          line_q[$];
    logic [10:0] exp_q[$];
    logic [10:0] obs_q[$];

    always #5 clk = ~clk;

    uart_recv #(.CLKS_PER_BIT(26), .CNT_W(8)) u_dut26 (
        .CLK(clk), .RST(rst), .RXD(rxd26), .DATA(data26),
        .DATA_READY(rdy26), .FRAME_ERR(fe26), .IDLE(idle26)
    );

    uart_recv #(.CLKS_PER_BIT(4), .CNT_W(3)) u_dut4 (
        .CLK(clk), .RST(rst), .RXD(rxd4), .DATA(data4),
        .DATA_READY(rdy4), .FRAME_ERR(fe4), .IDLE(idle4)
    );

    task automatic add_level(input bit v, input int n);
        for (int k = 0; k < n; k++) line_q.push_back(v);
    endtask

    task automatic add_frame(input int cpb, input logic [7:0] b, input bit stop);
        add_level(1'b0, cpb);
        for (int k = 0; k < 8; k++) add_level(b[k], cpb);
        add_level(stop, cpb);
    endtask

    // Receiver model over the line trace: a start edge at index n0 is sampled at
    // n0+cpb/2, bit k at n0+cpb/2+(k+1)*cpb, stop at n0+cpb/2+9*cpb; the
    // synchroniser plus output register make every effect visible 3 cycles later.
    task automatic build_expected(input int cpb, inout logic [7:0] d);
        int         n, h, j, n0, s, stp, hh, busy_end;
        logic [7:0] b;
        bit         idle_e[$], rdy_e[$], fe_e[$];
        logic [7:0] dat_e[$];
        n = line_q.size();
        h = cpb / 2;
        for (int k = 0; k < n; k++) begin
            idle_e.push_back(1'b1); rdy_e.push_back(1'b0);
            fe_e.push_back(1'b0);   dat_e.push_back(d);
        end
        j = 1;
        while (j < n) begin
            if (line_q[j-1] && !line_q[j]) begin
                n0 = j; s = j + h; stp = s + 9 * cpb;
                busy_end = n + 3; j = n;
                if (s < n && line_q[s]) begin
                    busy_end = s + 3; j = s + 1;
                end else if (s < n && stp < n) begin
                    for (int k = 0; k < 8; k++) b[k] = line_q[s + (k + 1) * cpb];
                    if (line_q[stp]) begin
                        busy_end = stp + 3; j = stp + 1; d = b;
                        if (stp + 3 < n) rdy_e[stp+3] = 1'b1;
                        for (int t = stp + 3; t < n; t++) dat_e[t] = b;
                    end else begin
                        if (stp + 3 < n) fe_e[stp+3] = 1'b1;
                        hh = stp + 1;
                        while (hh < n && !line_q[hh]) hh++;
                        if (hh < n) begin
                            busy_end = hh + 3; j = hh + 1;
                        end
                    end
                end
                for (int k = n0 + 3; k < busy_end && k < n; k++) idle_e[k] = 1'b0;
            end else begin
                j++;
            end
        end
        exp_q.delete();
        for (int k = 0; k < n; k++) exp_q.push_back({idle_e[k], rdy_e[k], fe_e[k], dat_e[k]});
    endtask

    // Observe on the falling edge, then drive the next line value.
    task automatic play(input bit sel);
        obs_q.delete();
        for (int k = 0; k < line_q.size(); k++) begin
            @(negedge clk);
            if (sel) obs_q.push_back({idle4, rdy4, fe4, data4});
            else     obs_q.push_back({idle26, rdy26, fe26, data26});
            if (sel) rxd4 = line_q[k];
            else     rxd26 = line_q[k];
        end
    endtask

    function automatic int pulse_at(input int nth, input int bitpos);
        int c = 0;
        for (int k = 0; k < obs_q.size(); k++) begin
            if (obs_q[k][bitpos] === 1'b1) begin
                if (c == nth) return k;
                c++;
            end
        end
        return -1;
    endfunction

    task automatic test_reset();
        repeat (4) @(negedge clk);
        vectors++;
        if ({idle26, rdy26, fe26, data26} !== {3'b100, 8'h00}) begin
            miscompares++;
            $display("FAIL reset26 got=%h exp=%h", {idle26, rdy26, fe26, data26}, {3'b100, 8'h00});
        end
        vectors++;
        if ({idle4, rdy4, fe4, data4} !== {3'b100, 8'h00}) begin
            miscompares++;
            $display("FAIL reset4 got=%h exp=%h", {idle4, rdy4, fe4, data4}, {3'b100, 8'h00});
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({idle26, rdy26, fe26} !== 3'b100) begin
            miscompares++;
            $display("FAIL post_reset_idle got=%b exp=100", {idle26, rdy26, fe26});
        end
        mdata26 = 8'h00;
        mdata4  = 8'h00;
    endtask

    task automatic test_single_byte();
        line_q.delete();
        add_level(1'b1, 4); add_frame(26, 8'hA5, 1'b1); add_level(1'b1, 10);
        build_expected(26, mdata26);
        play(1'b0);
        for (int k = 0; k < exp_q.size(); k++) begin
            vectors++;
            if (obs_q[k] !== exp_q[k]) begin
                miscompares++;
                $display("FAIL single_byte idx=%0d got=%h exp=%h", k, obs_q[k], exp_q[k]);
            end
        end
        vectors++;
        if (pulse_at(0, 9) !== 254 || pulse_at(1, 9) !== -1) begin
            miscompares++;
            $display("FAIL single_byte_latency got=%0d/%0d exp=254/-1", pulse_at(0, 9), pulse_at(1, 9));
        end
    endtask

    task automatic test_false_start();
        line_q.delete();
        add_level(1'b1, 4); add_level(1'b0, 5); add_level(1'b1, 30);
        build_expected(26, mdata26);
        play(1'b0);
        for (int k = 0; k < exp_q.size(); k++) begin
            vectors++;
            if (obs_q[k] !== exp_q[k]) begin
                miscompares++;
                $display("FAIL false_start idx=%0d got=%h exp=%h", k, obs_q[k], exp_q[k]);
            end
        end
        vectors++;
        if (obs_q[4+15][10] !== 1'b0 || obs_q[4+16][10] !== 1'b1) begin
            miscompares++;
            $display("FAIL false_start_idle got=%b%b exp=01", obs_q[19][10], obs_q[20][10]);
        end
    endtask

    task automatic test_frame_error();
        logic [7:0] prior;
        prior = mdata26;
        line_q.delete();
        add_level(1'b1, 4); add_frame(26, 8'h3C, 1'b0); add_level(1'b0, 100);
        add_level(1'b1, 20); add_frame(26, 8'h81, 1'b1); add_level(1'b1, 10);
        build_expected(26, mdata26);
        play(1'b0);
        for (int k = 0; k < exp_q.size(); k++) begin
            vectors++;
            if (obs_q[k] !== exp_q[k]) begin
                miscompares++;
                $display("FAIL frame_error idx=%0d got=%h exp=%h", k, obs_q[k], exp_q[k]);
            end
        end
        vectors++;
        if (pulse_at(0, 8) !== 254 || pulse_at(1, 8) !== -1 || obs_q[300][7:0] !== prior) begin
            miscompares++;
            $display("FAIL frame_error_pulse got=%0d/%0d data=%h exp=254/-1 data=%h",
                     pulse_at(0, 8), pulse_at(1, 8), obs_q[300][7:0], prior);
        end
        vectors++;
        if (data26 !== 8'h81) begin
            miscompares++;
            $display("FAIL frame_error_next got=%h exp=81", data26);
        end
    endtask

    task automatic test_back_to_back();
        line_q.delete();
        add_level(1'b1, 4); add_frame(26, 8'h00, 1'b1); add_frame(26, 8'hFF, 1'b1);
        add_level(1'b1, 10);
        build_expected(26, mdata26);
        play(1'b0);
        for (int k = 0; k < exp_q.size(); k++) begin
            vectors++;
            if (obs_q[k] !== exp_q[k]) begin
                miscompares++;
                $display("FAIL back_to_back idx=%0d got=%h exp=%h", k, obs_q[k], exp_q[k]);
            end
        end
        vectors++;
        if (pulse_at(1, 9) - pulse_at(0, 9) !== 260 || obs_q[254][7:0] !== 8'h00 || obs_q[514][7:0] !== 8'hFF) begin
            miscompares++;
            $display("FAIL back_to_back_spacing got=%0d exp=260", pulse_at(1, 9) - pulse_at(0, 9));
        end
    endtask

    task automatic test_cpb4();
        line_q.delete();
        add_level(1'b1, 4); add_frame(4, 8'h96, 1'b1); add_level(1'b1, 10);
        build_expected(4, mdata4);
        play(1'b1);
        for (int k = 0; k < exp_q.size(); k++) begin
            vectors++;
            if (obs_q[k] !== exp_q[k]) begin
                miscompares++;
                $display("FAIL cpb4 idx=%0d got=%h exp=%h", k, obs_q[k], exp_q[k]);
            end
        end
        vectors++;
        if (pulse_at(0, 9) !== 45 || obs_q[45][7:0] !== 8'h96) begin
            miscompares++;
            $display("FAIL cpb4_latency got=%0d data=%h exp=45 data=96", pulse_at(0, 9), obs_q[45][7:0]);
        end
    endtask

    task automatic test_random(input bit sel);
        int         cpb, kind, fs, o, k2;
        logic [7:0] b;
        cpb = sel ? 4 : 26;
        for (int it = 0; it < 3; it++) begin
            line_q.delete();
            add_level(1'b1, 4);
            for (int f = 0; f < 6; f++) begin
                kind = int'($urandom_range(0, 5));
                b    = 8'($urandom);
                fs   = line_q.size();
                if (kind == 0) begin
                    add_level(1'b0, int'($urandom_range(1, cpb / 2 - 1)));
                    add_level(1'b1, cpb);
                end else if (kind == 1) begin
                    add_frame(cpb, b, 1'b0);
                    add_level(1'b0, int'($urandom_range(1, 30)));
                    add_level(1'b1, int'($urandom_range(1, 4)));
                end else begin
                    add_frame(cpb, b, 1'b1);
                    if (kind == 2) begin
                        k2 = int'($urandom_range(1, 8));
                        o  = int'($urandom_range(0, cpb - 2));
                        if (o >= cpb / 2) o++;
                        line_q[fs + k2 * cpb + o] = !line_q[fs + k2 * cpb + o];
                    end
                    add_level(1'b1, int'($urandom_range(0, 4)));
                end
            end
            add_level(1'b1, cpb + 12);
            if (sel) build_expected(cpb, mdata4);
            else     build_expected(cpb, mdata26);
            play(sel);
            for (int k = 0; k < exp_q.size(); k++) begin
                vectors++;
                if (obs_q[k] !== exp_q[k]) begin
                    miscompares++;
                    $display("FAIL random cpb=%0d it=%0d idx=%0d got=%h exp=%h", cpb, it, k, obs_q[k], exp_q[k]);
                end
            end
        end
    endtask

    task automatic test_mid_frame_reset();
        line_q.delete();
        add_level(1'b1, 4); add_frame(26, 8'hC3, 1'b1);
        line_q = line_q[0:4+26*5+13-1];
        build_expected(26, mdata26);
        play(1'b0);
        for (int k = 0; k < exp_q.size(); k++) begin
            vectors++;
            if (obs_q[k] !== exp_q[k]) begin
                miscompares++;
                $display("FAIL mid_reset_prefix idx=%0d got=%h exp=%h", k, obs_q[k], exp_q[k]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if ({idle26, rdy26, fe26, data26} !== {3'b100, 8'h00}) begin
                miscompares++;
                $display("FAIL mid_reset_hold cyc=%0d got=%h exp=%h", k, {idle26, rdy26, fe26, data26}, {3'b100, 8'h00});
            end
        end
        rxd26 = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        mdata26 = 8'h00;
        mdata4  = 8'h00;
        line_q.delete();
        add_level(1'b1, 4); add_frame(26, 8'h5A, 1'b1); add_level(1'b1, 10);
        build_expected(26, mdata26);
        play(1'b0);
        for (int k = 0; k < exp_q.size(); k++) begin
            vectors++;
            if (obs_q[k] !== exp_q[k]) begin
                miscompares++;
                $display("FAIL mid_reset_after idx=%0d got=%h exp=%h", k, obs_q[k], exp_q[k]);
            end
        end
        vectors++;
        if (data26 !== 8'h5A) begin
            miscompares++;
            $display("FAIL mid_reset_data got=%h exp=5a", data26);
        end
    endtask

    initial begin
        rst   = 1'b0;
        rxd26 = 1'b1;
        rxd4  = 1'b1;
        test_reset();
        test_single_byte();
        test_false_start();
        test_frame_error();
        test_back_to_back();
        test_cpb4();
        test_random(1'b0);
        test_random(1'b1);
        test_mid_frame_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_recv.md
UART_RECV -- requirements
Module: uart_recv

Interface
REQ-001 Parameter CLKS_PER_BIT, default 26, gives the CLK cycles per serial bit; the block SHALL support values 4..255.
REQ-002 Parameter CNT_W, default 8, gives the width of the bit-period counter and SHALL satisfy 2^CNT_W > CLKS_PER_BIT.
REQ-003 Port CLK, input, 1 bit: the only clock; all state SHALL update on its rising edge.
REQ-004 Port RST, input, 1 bit: synchronous, active-low reset, sampled on the CLK rising edge.
REQ-005 Port RXD, input, 1 bit: asynchronous serial line, idle high, 8N1 framing, LSB first.
REQ-006 Port DATA, output, 8 bits: last correctly framed byte, held until the next good frame.
REQ-007 Port DATA_READY, output, 1 bit: one-cycle pulse when DATA has just been updated.
REQ-008 Port FRAME_ERR, output, 1 bit: one-cycle pulse when the stop bit is sampled 0.
REQ-009 Port IDLE, output, 1 bit: high when the FSM is in IDLE; low otherwise.

Function
REQ-010 RXD SHALL pass through a 2-flop synchronizer (rx_s), and a third flop SHALL hold rx_s of the previous cycle; all decisions SHALL use rx_s only.
REQ-011 The FSM states SHALL be IDLE, START, DATA, STOP and BREAK, all registered.
REQ-012 IDLE -> START SHALL occur when rx_s=0 and prev rx_s=1; the bit counter loads CLKS_PER_BIT/2 (integer division).
REQ-013 Let E be the edge on which START is entered; the start sample SHALL be at E+CLKS_PER_BIT/2 and data bit k (k=0..7) SHALL be sampled at E+CLKS_PER_BIT/2+(k+1)*CLKS_PER_BIT.
REQ-014 START: if rx_s=1 at the start sample (false start), the FSM SHALL return to IDLE with no output pulse; otherwise it SHALL go to DATA.
REQ-015 DATA: each sampled bit SHALL shift into an internal shift register from the MSB end; after bit 7 the FSM SHALL go to STOP.
REQ-016 STOP: the stop sample SHALL be at E+CLKS_PER_BIT/2+9*CLKS_PER_BIT.
REQ-017 At the stop sample with rx_s=1: DATA <= shift register, DATA_READY=1 for exactly the next cycle, and the FSM SHALL go to IDLE.
REQ-018 At the stop sample with rx_s=0: DATA SHALL be unchanged, FRAME_ERR=1 for exactly the next cycle, and the FSM SHALL go to BREAK.
REQ-019 BREAK SHALL remain until rx_s=1, then go to IDLE; no start detection SHALL occur in BREAK.
REQ-020 A falling edge SHALL be detectable on the first cycle back in IDLE, so a back-to-back frame whose start bit directly follows the stop bit is received.
REQ-021 Latency from the RXD pin to the rx_s edge SHALL be 2 cycles; DATA_READY SHALL rise 1 cycle after the stop sample.
REQ-022 DATA_READY and FRAME_ERR SHALL never be high in the same cycle.
REQ-023 RXD transitions within a bit other than at sample points SHALL have no effect (no glitch filter, single mid-bit sample).
REQ-024 The bit counter SHALL count down, reload CLKS_PER_BIT-1 after each sample, and never wrap past 0.

Reset
REQ-025 While RST=0 at a CLK edge: FSM=IDLE, DATA=8'h00, DATA_READY=0, FRAME_ERR=0, IDLE=1, synchronizer flops=1, counters=0.
REQ-026 Reset mid-frame SHALL abandon the frame with no pulse; after release, reception SHALL require a fresh falling edge.

Verification
REQ-027 Send 0xA5 (CLKS_PER_BIT=26) -> one DATA_READY pulse 250 cycles after the first low RXD sample, DATA=0xA5, FRAME_ERR never high.
REQ-028 Drive an RXD low pulse of 5 cycles, then high -> no pulses; IDLE=1 again 16 cycles after the edge; DATA unchanged.
REQ-029 Send 0x3C with stop bit 0, line held low 100 cycles, then high -> FRAME_ERR pulse once, DATA keeps its prior value, IDLE=1 only after the line returns high; a following 0x81 frame is received correctly.
REQ-030 Send 0x00 then 0xFF back-to-back with no gap -> two DATA_READY pulses 260 cycles apart, DATA=0x00 then 0xFF.
REQ-031 Assert RST=0 during data bit 4 of a frame -> outputs at reset values and no pulse; a 0x5A frame sent after release is received correctly.
REQ-032 Set CLKS_PER_BIT=4 and send 0x96 -> DATA=0x96, with DATA_READY 1 cycle after the stop sample at E+38.
